// File: rtl/load_store_unit.sv
// load_store_unit: variable-latency load/store unit between execute stage and data memory
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ip_req_valid,
  output logic              op_req_ready,
  input  logic              ip_req_store,
  input  logic [2:0]        ip_req_funct3,
  input  logic [XLEN-1:0]   ip_req_addr,
  input  logic [XLEN-1:0]   ip_req_wdata,
  output logic              op_resp_valid,
  output logic [XLEN-1:0]   op_resp_rdata,
  output logic              op_resp_err,
  output logic [1:0]        op_resp_cause,
  output logic [XLEN-1:0]   op_data_addr,
  output logic              op_data_wr,
  output logic [XLEN/8-1:0] op_data_mask,
  output logic [XLEN-1:0]   op_data_from_proc,
  output logic              op_data_rd,
  input  logic              ip_data_valid,
  input  logic [XLEN-1:0]   ip_data_from_dmem
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [OW-1:0] off;
  logic [2:0] f3;
  logic [2:0] am;
  logic [NB-1:0] ones;
  logic illegal, misal, timeout;
  logic [XLEN-1:0] sh, up, ldata;
  logic signed [XLEN-1:0] sx;
  logic [6:0] esh;

  assign op_req_ready = state == IDLE;

  // Request decode, timeout detect and load-result extraction
  always_comb begin
    am = 3'((4'd1 << ip_req_funct3[1:0]) - 4'd1);
    ones = NB'((9'd1 << (4'd1 << ip_req_funct3[1:0])) - 9'd1);
    illegal = ip_req_funct3 == 3'b111 || (ip_req_store && ip_req_funct3[2]) ||
              (XLEN == 32 && (ip_req_funct3 == 3'b011 || ip_req_funct3 == 3'b110));
    misal = |(ip_req_addr[2:0] & am);
    timeout = TIMEOUT != 0 && cnt == CW'(TIMEOUT) && !ip_data_valid;
    sh = ip_data_from_dmem >> {off, 3'b000};
    esh = 7'(XLEN) - (7'd8 << f3[1:0]);
    up = sh << esh;
    sx = $signed(up) >>> esh;
    ldata = f3[2] ? up >> esh : sx;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = ip_req_valid ? ((illegal || misal) ? RESP : BUSY) : IDLE;
      BUSY: state_n = (ip_data_valid || timeout) ? RESP : BUSY;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  // Registered bus and response outputs; response fields live for one cycle only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_resp_valid <= 1'b0;
      op_resp_rdata <= '0;
      op_resp_err <= 1'b0;
      op_resp_cause <= 2'd0;
      op_data_addr <= '0;
      op_data_wr <= 1'b0;
      op_data_rd <= 1'b0;
      op_data_mask <= '0;
      op_data_from_proc <= '0;
      cnt <= '0;
      off <= '0;
      f3 <= 3'd0;
    end else begin
      op_resp_valid <= 1'b0;
      op_resp_rdata <= '0;
      op_resp_err <= 1'b0;
      op_resp_cause <= 2'd0;
      if (state == IDLE && ip_req_valid) begin
        if (illegal || misal) begin
          op_resp_valid <= 1'b1;
          op_resp_err <= 1'b1;
          op_resp_cause <= illegal ? 2'd3 : 2'd1;
        end else begin
          op_data_addr <= ip_req_addr & ~XLEN'(NB - 1);
          op_data_rd <= !ip_req_store;
          op_data_wr <= ip_req_store;
          op_data_mask <= ones << ip_req_addr[OW-1:0];
          op_data_from_proc <= ip_req_wdata << {ip_req_addr[OW-1:0], 3'b000};
          off <= ip_req_addr[OW-1:0];
          f3 <= ip_req_funct3;
          cnt <= '0;
        end
      end else if (state == BUSY) begin
        if (ip_data_valid || timeout) begin
          op_data_addr <= '0;
          op_data_rd <= 1'b0;
          op_data_wr <= 1'b0;
          op_data_mask <= '0;
          op_data_from_proc <= '0;
          op_resp_valid <= 1'b1;
          op_resp_rdata <= (ip_data_valid && op_data_rd) ? ldata : '0;
          op_resp_err <= !ip_data_valid;
          op_resp_cause <= ip_data_valid ? 2'd0 : 2'd2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of 32-bit (TIMEOUT=4) and 64-bit load/store units
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic sel, req_valid, req_store, dvalid;
  logic [2:0] f3;
  logic [63:0] addr, wdata, dmem;

  logic r32, rv32, err32, wr32, rd32;
  logic [1:0] c32;
  logic [31:0] rdata32, da32, fp32;
  logic [3:0] m32;
  logic r64, rv64, err64, wr64, rd64;
  logic [1:0] c64;
  logic [63:0] rdata64, da64, fp64;
  logic [7:0] m64;

  load_store_unit #(.XLEN(32), .TIMEOUT(4)) d32 (
    .clk(clk), .reset(reset), .ip_req_valid(req_valid & !sel), .op_req_ready(r32),
    .ip_req_store(req_store), .ip_req_funct3(f3), .ip_req_addr(addr[31:0]),
    .ip_req_wdata(wdata[31:0]), .op_resp_valid(rv32), .op_resp_rdata(rdata32),
    .op_resp_err(err32), .op_resp_cause(c32), .op_data_addr(da32), .op_data_wr(wr32),
    .op_data_mask(m32), .op_data_from_proc(fp32), .op_data_rd(rd32),
    .ip_data_valid(dvalid & !sel), .ip_data_from_dmem(dmem[31:0])
  );

  load_store_unit #(.XLEN(64)) d64 (
    .clk(clk), .reset(reset), .ip_req_valid(req_valid & sel), .op_req_ready(r64),
    .ip_req_store(req_store), .ip_req_funct3(f3), .ip_req_addr(addr),
    .ip_req_wdata(wdata), .op_resp_valid(rv64), .op_resp_rdata(rdata64),
    .op_resp_err(err64), .op_resp_cause(c64), .op_data_addr(da64), .op_data_wr(wr64),
    .op_data_mask(m64), .op_data_from_proc(fp64), .op_data_rd(rd64),
    .ip_data_valid(dvalid & sel), .ip_data_from_dmem(dmem)
  );

  // Outputs of whichever unit is currently selected, widened to 64 bits
  logic a_ready, a_rv, a_err, a_wr, a_rd;
  logic [1:0] a_cause;
  logic [63:0] a_rdata, a_daddr, a_fp;
  logic [7:0] a_mask;
  always_comb begin
    a_ready = sel ? r64 : r32;
    a_rv = sel ? rv64 : rv32;
    a_err = sel ? err64 : err32;
    a_cause = sel ? c64 : c32;
    a_rdata = sel ? rdata64 : {32'b0, rdata32};
    a_wr = sel ? wr64 : wr32;
    a_rd = sel ? rd64 : rd32;
    a_mask = sel ? m64 : {4'b0, m32};
    a_daddr = sel ? da64 : {32'b0, da32};
    a_fp = sel ? fp64 : {32'b0, fp32};
  end

  int n_err = 0, n_chk = 0;
  logic chk_en = 1'b0;
  logic e_ready, e_rv, e_err, e_wr, e_rd;
  logic [1:0] e_cause;
  logic [63:0] e_rdata, e_daddr, e_fp;
  logic [7:0] e_mask;
  logic [63:0] last_rdata, last_daddr, last_fp;
  logic [7:0] last_mask;
  logic [1:0] last_cause;
  logic last_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    e_ready = 1'b1; e_rv = 1'b0; e_err = 1'b0; e_cause = 2'd0; e_rdata = '0;
    e_wr = 1'b0; e_rd = 1'b0; e_mask = '0; e_daddr = '0; e_fp = '0;
  endtask

  // Spec-level reference for one access: cause, bus image and load result
  function automatic void model(input int x, input logic st, input logic [2:0] f,
                                input logic [63:0] a, input logic [63:0] wd, input logic [63:0] dm,
                                output logic [1:0] cause, output logic [63:0] daddr,
                                output logic [63:0] fp, output logic [63:0] rdata,
                                output logic [7:0] mask);
    int nb = x / 8;
    int sz = 1 << f[1:0];
    int o = int'(a % 64'(nb));
    logic [127:0] xm, lim, raw;
    logic ill;
    ill = f == 3'b111 || (st && f[2]) || (x == 32 && (f == 3'b011 || f == 3'b110));
    cause = ill ? 2'd3 : (a % 64'(sz) != 0) ? 2'd1 : 2'd0;
    xm = (128'd1 << x) - 128'd1;
    daddr = a - 64'(o);
    mask = 8'(((1 << sz) - 1) << o);
    fp = 64'((({64'b0, wd} & xm) << (8 * o)) & xm);
    lim = (128'd1 << (8 * sz)) - 128'd1;
    raw = (({64'b0, dm} & xm) >> (8 * o)) & lim;
    if (!f[2] && raw[8 * sz - 1]) raw = raw | ~lim;
    rdata = st ? 64'd0 : 64'(raw & xm);
  endfunction

  // Single compare process: every negedge, selected unit vs expectation
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {63'b0, a_ready}, {63'b0, e_ready});
      chk("resp_valid", {63'b0, a_rv}, {63'b0, e_rv});
      chk("resp_rdata", a_rdata, e_rdata);
      chk("resp_err", {63'b0, a_err}, {63'b0, e_err});
      chk("resp_cause", {62'b0, a_cause}, {62'b0, e_cause});
      chk("data_rd", {63'b0, a_rd}, {63'b0, e_rd});
      chk("data_wr", {63'b0, a_wr}, {63'b0, e_wr});
      chk("data_mask", {56'b0, a_mask}, {56'b0, e_mask});
      if (e_rd || e_wr) begin
        chk("data_addr", a_daddr, e_daddr);
        chk("data_from_proc", a_fp, e_fp);
      end
      if (a_rv) begin
        last_rdata = a_rdata; last_err = a_err; last_cause = a_cause;
      end
      if (a_rd || a_wr) begin
        last_mask = a_mask; last_daddr = a_daddr; last_fp = a_fp;
      end
    end
  end

  // One access; starts and ends 1 time unit after a rising edge with the unit idle
  task automatic run(input logic s, input logic st, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] dm, input int waits);
    logic [1:0] cause;
    logic [63:0] daddr, fp, rd;
    logic [7:0] mk;
    int to = s ? 255 : 4;
    int k = 0;
    model(s ? 64 : 32, st, f, a, wd, dm, cause, daddr, fp, rd, mk);
    sel = s; req_valid = 1'b1; req_store = st; f3 = f; addr = a; wdata = wd; dmem = dm; dvalid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e_ready = 1'b0;
    if (cause != 2'd0) begin
      e_rv = 1'b1; e_err = 1'b1; e_cause = cause;
    end else begin
      e_rd = !st; e_wr = st; e_mask = mk; e_daddr = daddr; e_fp = fp;
      dvalid = waits == 0;
      @(posedge clk); #1;
      while (k != waits && k != to) begin
        k++;
        dvalid = k == waits;
        @(posedge clk); #1;
      end
      dvalid = 1'b0;
      e_rd = 1'b0; e_wr = 1'b0; e_mask = '0; e_rv = 1'b1;
      if (k == waits) e_rdata = rd;
      else begin e_err = 1'b1; e_cause = 2'd2; end
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_store = 1'b0; f3 = 3'd0;
    addr = '0; wdata = '0; dmem = '0; dvalid = 1'b0;
    set_idle();
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run(0, 0, 3'b010, 64'h100, 0, 64'hDEADBEEF, 0);
    chk("lw_lit", last_rdata, 64'hDEADBEEF);
    chk("lw_mask_lit", {56'b0, last_mask}, 64'hF);
    run(0, 0, 3'b000, 64'h103, 0, 64'h80123456, 1);
    chk("lb_lit", last_rdata, 64'hFFFFFF80);
    run(0, 0, 3'b100, 64'h103, 0, 64'h80123456, 0);
    chk("lbu_lit", last_rdata, 64'h80);
    run(0, 0, 3'b101, 64'h102, 0, 64'hBEEF1234, 2);
    chk("lhu_lit", last_rdata, 64'hBEEF);
    run(0, 0, 3'b001, 64'h102, 0, 64'hBEEF1234, 0);
    chk("lh_lit", last_rdata, 64'hFFFFBEEF);
    run(0, 1, 3'b001, 64'h206, 64'h1234ABCD, 0, 3);
    chk("sh_addr_lit", last_daddr, 64'h204);
    chk("sh_mask_lit", {56'b0, last_mask}, 64'hC);
    chk("sh_data_lit", last_fp, 64'hABCD0000);
    chk("sh_err_lit", {63'b0, last_err}, 64'h0);
    run(0, 1, 3'b000, 64'h101, 64'h55, 0, 0);
    chk("sb_data_lit", last_fp, 64'h5500);
    run(0, 1, 3'b010, 64'h10, 64'h01020304, 0, 1);
    run(0, 0, 3'b010, 64'h101, 0, 0, 0);
    chk("misal_lit", {62'b0, last_cause}, 64'd1);
    run(0, 0, 3'b011, 64'h100, 0, 0, 0);
    chk("ld32_lit", {62'b0, last_cause}, 64'd3);
    run(0, 0, 3'b011, 64'h101, 0, 0, 0);
    chk("ld32_misal_lit", {62'b0, last_cause}, 64'd3);
    run(0, 0, 3'b111, 64'h100, 0, 0, 0);
    run(0, 1, 3'b100, 64'h100, 0, 0, 0);
    run(0, 0, 3'b001, 64'h101, 0, 0, 0);

    dvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1 dvalid = 1'b0;

    run(0, 0, 3'b010, 64'h100, 0, 64'h11111111, 100);
    chk("timeout_lit", {62'b0, last_cause}, 64'd2);
    run(0, 0, 3'b010, 64'h104, 0, 64'h22222222, 2);
    chk("after_to_lit", last_rdata, 64'h22222222);
    run(0, 0, 3'b010, 64'h108, 0, 64'h33333333, 4);
    chk("edge_valid_lit", {63'b0, last_err}, 64'h0);

    chk_en = 1'b0;
    sel = 1'b0; req_valid = 1'b1; req_store = 1'b0; f3 = 3'b010; addr = 64'h300; dmem = 64'h44444444;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_rd", {63'b0, rd32}, 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", {63'b0, r32}, 64'h1);
    chk("rst_rd", {63'b0, rd32}, 64'h0);
    chk("rst_addr", {32'b0, da32}, 64'h0);
    chk("rst_mask", {60'b0, m32}, 64'h0);
    chk("rst_rv", {63'b0, rv32}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    dvalid = 1'b1;
    set_idle();
    chk_en = 1'b1;
    @(posedge clk); #1;
    dvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run(1, 0, 3'b011, 64'h8, 0, 64'h0123456789ABCDEF, 0);
    chk("ld64_lit", last_rdata, 64'h0123456789ABCDEF);
    run(1, 0, 3'b110, 64'hC, 0, 64'hFFFFFFFF00000000, 1);
    chk("lwu64_lit", last_rdata, 64'h00000000FFFFFFFF);
    run(1, 0, 3'b010, 64'hC, 0, 64'hFFFFFFFF00000000, 0);
    chk("lw64_lit", last_rdata, 64'hFFFFFFFFFFFFFFFF);
    run(1, 1, 3'b010, 64'h14, 64'hCAFEBABE, 0, 2);
    chk("sw64_mask_lit", {56'b0, last_mask}, 64'hF0);
    chk("sw64_data_lit", last_fp, 64'hCAFEBABE00000000);
    run(1, 1, 3'b011, 64'h10, 64'h1122334455667788, 0, 1);
    run(1, 0, 3'b011, 64'h4, 0, 0, 0);
    run(1, 1, 3'b110, 64'h8, 0, 0, 0);
    run(1, 0, 3'b000, 64'h7, 0, 64'h80FFFFFFFFFFFFFF, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
